// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and helpers for the nibble-serial adder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nib_count(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/add4_slice.sv
// rtl/add4_slice.sv - 4-bit combinational ripple-carry adder stage
module add4_slice
  import adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[SLICE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder that time-multiplexes one 4-bit
// slice LSB first, with valid/ready on both operand and result sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               co_sl;

  // Slice offset is idx*4, formed by concatenation so the index width matches the operand.
  assign a_sl = a_q[{idx, 2'b00} +: SLICE_W];
  assign b_sl = b_q[{idx, 2'b00} +: SLICE_W];

  add4_slice u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: SLICE_W] <= s_sl;
          carry <= co_sl;
          idx   <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            cout  <= co_sl;
            // a^b^s at the top bit recovers the carry into the MSB.
            ovf   <= a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ s_sl[SLICE_W-1] ^ co_sl;
            idx   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        cin32 = 1'b0;
  logic        out_valid32;
  logic        out_ready32 = 1'b0;
  logic [31:0] sum32;
  logic        cout32;
  logic        ovf32;
  logic        busy32;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .cin(cin32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .sum(sum32), .cout(cout32), .ovf(ovf32), .busy(busy32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands and passes the accept edge; returns #1 after it.
  task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done16(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic release16(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic op16(input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    start16(av, bv, cv);
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done16(tag, lat);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    release16(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] held_sum;

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    op16("basic",  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    op16("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("posovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Backpressure: DONE must hold while in_valid and operands wiggle.
    start16(16'h00F0, 16'h0F0F, 1'b0);
    wait_done16("bp", lat);
    held_sum = 16'h0FFF;
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      a = 16'hA5A5 ^ 16'(i);
      tick();
      check("bp_sum", {16'd0, sum}, {16'd0, held_sum});
      check("bp_cout", {31'd0, cout}, 32'd0);
      check("bp_ovf", {31'd0, ovf}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    release16("bp");

    // Reset landing on the second RUN edge discards the partial result.
    start16(16'hFFFF, 16'h0001, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_result", {31'd0, out_valid}, 32'd0);
    end
    op16("after_rst", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

    // 32-bit instance: eight slices.
    a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; cin32 = 1'b1; in_valid32 = 1'b1;
    check("w32_in_ready", {31'd0, in_ready32}, 32'd1);
    tick();
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 40) begin
      tick();
      lat++;
    end
    check("w32_latency", lat, 8);
    check("w32_sum", sum32, 32'h0000_0001);
    check("w32_cout", {31'd0, cout32}, 32'd1);
    check("w32_ovf", {31'd0, ovf32}, 32'd0);
    out_ready32 = 1'b1;
    tick();
    out_ready32 = 1'b0;
    check("w32_in_ready_after", {31'd0, in_ready32}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
